// File: rtl/xm23_fetch_unit_pkg.sv
// Shared widths, FSM encoding and queue entry layout for the XM23 fetch stage.
package xm23_fetch_unit_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/xm23_fetch_unit_fetch_queue.sv
// Prefetch queue of {pc, instr} entries. Entry 0 is always the head, so the
// decoder-facing outputs come straight from flops.
module xm23_fetch_unit_fetch_queue
   import xm23_fetch_unit_pkg::*;
#(
   parameter int QDEPTH = 2,
   parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [ADDR_W+WORD_W-1:0] push_data,
   input  logic                     pop,
   output logic [ADDR_W+WORD_W-1:0] head,
   output logic [CNT_W-1:0]         count
);

   fetch_entry_t     slot_q [QDEPTH];
   fetch_entry_t     slot_d [QDEPTH];
   fetch_entry_t     above  [QDEPTH];
   fetch_entry_t     new_entry;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] wr_idx;
   logic             do_push;
   logic             do_pop;

   assign new_entry = fetch_entry_t'(push_data);
   assign do_pop    = pop & (count_q != '0);
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push   = push & ((count_q != CNT_W'(QDEPTH)) | do_pop);
   assign wr_idx    = count_q - CNT_W'(do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < QDEPTH; gi++) begin : g_above
         if (gi < QDEPTH - 1) begin : g_mid
            assign above[gi] = slot_q[gi+1];
         end else begin : g_last
            assign above[gi] = slot_q[gi];
         end
      end
   endgenerate

   always_comb begin
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush) begin
         count_d = '0;
      end
      for (int i = 0; i < QDEPTH; i++) begin
         slot_d[i] = do_pop ? above[i] : slot_q[i];
         if (do_push && (wr_idx == CNT_W'(i))) begin
            slot_d[i] = new_entry;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < QDEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign head  = slot_q[0];
   assign count = count_q;

endmodule

// File: rtl/xm23_fetch_unit.sv
// XM23 instruction fetch: PC, single-outstanding word reads, breakpoint halt,
// redirect flush, and a prefetch queue feeding the decoder.
module xm23_fetch_unit
   import xm23_fetch_unit_pkg::*;
#(
   parameter int          QDEPTH   = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        slp,
   input  logic [15:0] bkpnt,
   input  logic        bkpnt_en,
   input  logic        redir_valid,
   input  logic [15:0] redir_pc,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready,
   output logic        bkpt_hit,
   output logic        misalign
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_e         state_q;
   fetch_state_e         state_d;
   logic [ADDR_W-1:0]    pc_q;
   logic [ADDR_W-1:0]    pc_d;
   logic                 drop_q;
   logic                 drop_d;
   logic                 misalign_q;
   logic                 misalign_d;

   logic                 q_push;
   logic                 q_pop;
   logic [CNT_W-1:0]     q_count;
   logic [ADDR_W+WORD_W-1:0] q_head;
   fetch_entry_t         q_in;
   logic [CNT_W:0]       count_after;
   logic                 bkpt_match;
   logic                 outstanding;
   logic                 issue_ok;

   assign bkpt_match  = bkpnt_en & (pc_q == bkpnt);
   assign outstanding = drop_q | (state_q == ST_WAIT);
   assign q_push      = mem_rvalid & (state_q == ST_WAIT) & ~drop_q & ~redir_valid;
   assign q_pop       = instr_valid & instr_ready & ~redir_valid;
   // PC has already advanced by the time the word returns.
   assign q_in.pc     = pc_q - PC_STEP;
   assign q_in.instr  = mem_rdata;
   assign count_after = {1'b0, q_count} + (CNT_W+1)'(q_push) - (CNT_W+1)'(q_pop);
   // A pending dropped read still occupies the single outstanding slot.
   assign issue_ok    = ~slp & ~drop_q & (count_after < (CNT_W+1)'(QDEPTH));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q & ~mem_rvalid;
      misalign_d = redir_valid & redir_pc[0];

      case (state_q)
         ST_IDLE: begin
            if (bkpt_match) begin
               state_d = ST_HALT;
            end else if (issue_ok) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d = ST_WAIT;
               pc_d    = pc_inc(pc_q);
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (bkpt_match) begin
                  state_d = ST_HALT;
               end else if (issue_ok) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_HALT: begin
            if (!bkpnt_en) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (redir_valid) begin
         state_d = ST_IDLE;
         pc_d    = {redir_pc[15:1], 1'b0};
         drop_d  = (outstanding & ~mem_rvalid) | ((state_q == ST_REQ) & mem_gnt);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         misalign_q <= misalign_d;
      end
   end

   xm23_fetch_unit_fetch_queue #(
      .QDEPTH (QDEPTH),
      .CNT_W  (CNT_W)
   ) u_queue (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .flush     (redir_valid),
      .push      (q_push),
      .push_data (q_in),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count)
   );

   assign mem_req     = (state_q == ST_REQ);
   assign mem_addr    = mem_req ? pc_q : '0;
   assign instr_valid = (q_count != '0);
   assign instr       = q_head[WORD_W-1:0];
   assign instr_pc    = q_head[ADDR_W+WORD_W-1:WORD_W];
   assign bkpt_hit    = (state_q == ST_HALT);
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_xm23_fetch_unit.sv
// Directed bench for xm23_fetch_unit with a simple memory model (word = addr + 1000h).
module tb_xm23_fetch_unit;

   logic        Clock;
   logic        Reset_n;
   logic        slp;
   logic [15:0] bkpnt;
   logic        bkpnt_en;
   logic        redir_valid;
   logic [15:0] redir_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;
   logic        bkpt_hit;
   logic        misalign;

   int tests = 0;
   int fails = 0;

   // memory model
   int          gnt_lat;
   int          rv_lat;
   int          age = 0;
   logic        rv_q = 1'b0;
   logic [15:0] rd_q = 16'h0000;
   logic        pend_q = 1'b0;
   int          pend_cnt = 0;
   logic [15:0] pend_addr = 16'h0000;
   logic        stray_rv;

   logic [15:0] log_pc[$];
   logic [15:0] log_in[$];
   logic [15:0] gnt_log[$];
   int          base_l;
   int          base_g;

   xm23_fetch_unit dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .slp         (slp),
      .bkpnt       (bkpnt),
      .bkpnt_en    (bkpnt_en),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .bkpt_hit    (bkpt_hit),
      .misalign    (misalign)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   assign mem_gnt    = mem_req && (age >= gnt_lat);
   assign mem_rvalid = rv_q | stray_rv;
   assign mem_rdata  = rd_q;

   always @(posedge Clock) begin
      rv_q <= 1'b0;
      age  <= (mem_req && !mem_gnt) ? age + 1 : 0;
      if (pend_q) begin
         if (pend_cnt == 0) begin
            rv_q   <= 1'b1;
            rd_q   <= pend_addr + 16'h1000;
            pend_q <= 1'b0;
         end else begin
            pend_cnt <= pend_cnt - 1;
         end
      end
      if (mem_req && mem_gnt) begin
         if (rv_lat <= 1) begin
            rv_q <= 1'b1;
            rd_q <= mem_addr + 16'h1000;
         end else begin
            pend_q    <= 1'b1;
            pend_cnt  <= rv_lat - 2;
            pend_addr <= mem_addr;
         end
      end
   end

   always @(posedge Clock) begin
      if (Reset_n && instr_valid && instr_ready && !redir_valid) begin
         log_pc.push_back(instr_pc);
         log_in.push_back(instr);
      end
      if (Reset_n && mem_req && mem_gnt) begin
         gnt_log.push_back(mem_addr);
      end
   end

   function automatic logic [15:0] pc_at(input int idx);
      if (idx < log_pc.size()) return log_pc[idx];
      return 16'hxxxx;
   endfunction

   function automatic logic [15:0] in_at(input int idx);
      if (idx < log_in.size()) return log_in[idx];
      return 16'hxxxx;
   endfunction

   function automatic logic [15:0] gnt_at(input int idx);
      if (idx < gnt_log.size()) return gnt_log[idx];
      return 16'hxxxx;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] check %s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge Clock);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      tick(3);
      base_l  = log_pc.size();
      base_g  = gnt_log.size();
      Reset_n = 1'b1;
   endtask

   task automatic wait_req_gnt(input string tag);
      int n;
      for (n = 0; n < 40; n++) begin
         if (mem_req && mem_gnt) break;
         @(negedge Clock);
      end
      check(tag, 32'(n < 40), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int n;
      for (n = 0; n < 40; n++) begin
         if (mem_req) break;
         @(negedge Clock);
      end
      check(tag, 32'(n < 40), 32'd1);
   endtask

   task automatic redirect(input logic [15:0] pc);
      redir_valid = 1'b1;
      redir_pc    = pc;
      tick(1);
      redir_valid = 1'b0;
      base_l      = log_pc.size();
      base_g      = gnt_log.size();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n     = 1'b0;
      slp         = 1'b0;
      bkpnt       = 16'h0000;
      bkpnt_en    = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = 16'h0000;
      instr_ready = 1'b1;
      stray_rv    = 1'b0;
      gnt_lat     = 0;
      rv_lat      = 1;

      // Reset state and in-order delivery with 1-cycle memory
      Reset_n = 1'b0;
      tick(3);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_pc", 32'(instr_pc), 32'd0);
      check("rst_bkpt", 32'(bkpt_hit), 32'd0);
      check("rst_mis", 32'(misalign), 32'd0);
      base_l  = log_pc.size();
      base_g  = gnt_log.size();
      Reset_n = 1'b1;
      tick(20);
      check("t1_cnt", 32'(log_pc.size() - base_l >= 3), 32'd1);
      check("t1_pc0", 32'(pc_at(base_l)), 32'h0000);
      check("t1_in0", 32'(in_at(base_l)), 32'h1000);
      check("t1_pc1", 32'(pc_at(base_l + 1)), 32'h0002);
      check("t1_in1", 32'(in_at(base_l + 1)), 32'h1002);
      check("t1_pc2", 32'(pc_at(base_l + 2)), 32'h0004);
      check("t1_in2", 32'(in_at(base_l + 2)), 32'h1004);

      // Decoder stalled: queue fills to QDEPTH and fetching stops
      instr_ready = 1'b0;
      do_reset();
      tick(12);
      check("t2_valid", 32'(instr_valid), 32'd1);
      check("t2_headpc", 32'(instr_pc), 32'h0000);
      check("t2_head", 32'(instr), 32'h1000);
      check("t2_req", 32'(mem_req), 32'd0);
      check("t2_gnts", 32'(gnt_log.size() - base_g), 32'd2);
      base_l      = log_pc.size();
      instr_ready = 1'b1;
      tick(2);
      check("t2_pc0", 32'(pc_at(base_l)), 32'h0000);
      check("t2_pc1", 32'(pc_at(base_l + 1)), 32'h0002);
      check("t2_in1", 32'(in_at(base_l + 1)), 32'h1002);

      // Breakpoint at 0006: 0..4 delivered, no fetch of 0006
      bkpnt    = 16'h0006;
      bkpnt_en = 1'b1;
      do_reset();
      tick(20);
      check("t3_hit", 32'(bkpt_hit), 32'd1);
      check("t3_req", 32'(mem_req), 32'd0);
      check("t3_gnts", 32'(gnt_log.size() - base_g), 32'd3);
      check("t3_lastgnt", 32'(gnt_at(gnt_log.size() - 1)), 32'h0004);
      check("t3_cnt", 32'(log_pc.size() - base_l), 32'd3);
      check("t3_pc2", 32'(pc_at(base_l + 2)), 32'h0004);
      redirect(16'h0100);
      check("t3_hitclr", 32'(bkpt_hit), 32'd0);
      check("t3_mis", 32'(misalign), 32'd0);
      tick(10);
      check("t3_rpc", 32'(pc_at(base_l)), 32'h0100);
      check("t3_rin", 32'(in_at(base_l)), 32'h1100);

      // Odd redirect while a slow read is in flight
      bkpnt_en = 1'b0;
      rv_lat   = 3;
      tick(5);
      wait_req_gnt("t4_wait_gnt");
      tick(1);
      redirect(16'h0201);
      check("t4_mis", 32'(misalign), 32'd1);
      check("t4_flush", 32'(instr_valid), 32'd0);
      tick(1);
      check("t4_mis_pulse", 32'(misalign), 32'd0);
      tick(15);
      check("t4_gnt0", 32'(gnt_at(base_g)), 32'h0200);
      check("t4_pc0", 32'(pc_at(base_l)), 32'h0200);
      check("t4_in0", 32'(in_at(base_l)), 32'h1200);

      // Sleep raised during a delayed grant: exactly one fetch completes
      rv_lat  = 1;
      gnt_lat = 3;
      do_reset();
      wait_req("t5_wait_req");
      slp = 1'b1;
      tick(1);
      check("t5_req_held", 32'(mem_req), 32'd1);
      tick(12);
      check("t5_req", 32'(mem_req), 32'd0);
      check("t5_gnts", 32'(gnt_log.size() - base_g), 32'd1);
      check("t5_gnt0", 32'(gnt_at(base_g)), 32'h0000);
      check("t5_cnt", 32'(log_pc.size() - base_l), 32'd1);
      check("t5_pc0", 32'(pc_at(base_l)), 32'h0000);
      stray_rv = 1'b1;
      tick(1);
      stray_rv = 1'b0;
      tick(1);
      check("t5_stray", 32'(instr_valid), 32'd0);

      // PC wrap from FFFE to 0000
      gnt_lat = 0;
      slp     = 1'b0;
      redirect(16'hFFFE);
      tick(10);
      check("t6_gnt0", 32'(gnt_at(base_g)), 32'hFFFE);
      check("t6_gnt1", 32'(gnt_at(base_g + 1)), 32'h0000);
      check("t6_pc0", 32'(pc_at(base_l)), 32'hFFFE);
      check("t6_in0", 32'(in_at(base_l)), 32'h0FFE);
      check("t6_pc1", 32'(pc_at(base_l + 1)), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
